cpri_tx_pkg_sched: RTL and testbench
====================================

# cpri_tx_pkg_sched

Packet-level scheduler that shares one CPRI TX packet buffer write port between four UL packers. Each packer raises a request per packet. The scheduler grants one packer at a time in round-robin order, provided the downstream ping-pong/ring buffer has a free packet slot. It forwards that packer's write beats with the buffer slot pointer prepended to the address, and aborts packets that stall past a watchdog limit. It sits between the per-lane packers and the CPRI TX generator in the 491.52 MHz domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (logic is written for 4; other values are out of scope)
- ADDR_W, 7, in-packet beat address width
- DATA_W, 64, beat data width
- NUM_BUF, 4, packet slots in downstream buffer (power of 2)
- TIMEOUT, 256, maximum cycles a grant is held without wlast

Ports:
- clk  in  1  sys 491.52 MHz clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  4  per-packer packet request (level)
- o_gnt  out  4  one-hot grant
- i_wen  in  4  per-packer beat write enable
- i_waddr  in  4*ADDR_W  per-packer beat address, packer k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  4*DATA_W  per-packer beat data
- i_wlast  in  4  per-packer last beat of packet
- i_buf_rel  in  1  one-cycle pulse from reader: one packet slot freed
- o_cpri_wen  out  1  forwarded write enable
- o_cpri_waddr  out  log2(NUM_BUF)+ADDR_W  {slot_ptr, beat addr}
- o_cpri_wdata  out  DATA_W  forwarded data
- o_cpri_wlast  out  1  forwarded last beat
- o_credit  out  log2(NUM_BUF)+1  free slots
- o_timeout  out  1  one-cycle pulse on abort
- o_timeout_id  out  2  packer index of last abort
- o_pkt_cnt  out  16  completed packets, wraps

## Operation
- States: IDLE, XFER, ABORT.
- IDLE: if credit>0 and any i_req, pick the first requester at or after (last_winner+1) mod 4, set o_gnt one-hot, clear timer, go to XFER. If credit==0, no grant is issued and requests wait.
- XFER:
  - Only the granted packer's i_wen/i_waddr/i_wdata/i_wlast are registered onto the outputs. o_cpri_waddr = {slot_ptr, i_waddr[k]}.
  - Beats from non-granted packers are dropped silently.
  - Dropping i_req during XFER has no effect; the grant holds until wlast or timeout.
  - Granted wen&wlast: o_gnt cleared, slot_ptr+1 (mod NUM_BUF), credit−1, o_pkt_cnt+1, last_winner=k, return to IDLE.
  - The timer increments every XFER cycle. If it reaches TIMEOUT−1 without a granted wlast, go to ABORT.
- ABORT (1 cycle):
  - o_gnt cleared, o_timeout=1, o_timeout_id=k, last_winner=k.
  - slot_ptr and credit are unchanged; the partial slot is overwritten by the next packet.
  - o_cpri_wen=0. Return to IDLE.
- Credit:
  - Initialised to NUM_BUF.
  - i_buf_rel increments it. A packet completion in the same cycle gives net 0.
  - i_buf_rel while credit==NUM_BUF is ignored (saturate).
  - Credit never goes below 0, because grants are gated.
- wlast on a beat with wen=0 is ignored.

## Timing
- Reset values:
  - o_gnt=0, all o_cpri_*=0, o_credit=NUM_BUF, o_timeout=0, o_timeout_id=0, o_pkt_cnt=0.
  - Internally: slot_ptr=0, last_winner=3 (so packer 0 wins first), state IDLE.
- Grant latency: i_req sampled high in IDLE gives o_gnt high the next cycle.
- Beat latency: a granted beat at cycle t appears on o_cpri_* at t+1 (registered, 1 cycle).
- Completion: o_gnt deasserts the cycle after the wlast beat is sampled, coincident with o_cpri_wlast. The state is IDLE in that cycle, so at least 1 dead cycle separates grants.
- o_credit, slot_ptr and o_pkt_cnt update in the same cycle o_cpri_wlast is asserted.
- Abort: o_timeout is asserted TIMEOUT+1 cycles after o_gnt rose.
- Reset asserted mid-packet: all outputs return to reset values immediately; the partial packet is discarded.

## Test plan
- Single packer 0, 8 beats, addr 0..7, data 0xA0..0xA7 → o_gnt=0001 one cycle after req. o_cpri_waddr=0x000..0x007 delayed 1 cycle. Then o_credit=3 and o_pkt_cnt=1.
- All 4 packers request continuously, 4-beat packets, i_buf_rel pulsed after each completion → grant order 0,1,2,3,0. Slot field cycles 0,1,2,3,0. o_credit stays between 3 and 4.
- Credit exhaustion: 4 packets complete with no i_buf_rel → o_credit=0 and no grant while req is high. One i_buf_rel pulse → grant one cycle later.
- Simultaneous i_buf_rel and wlast at credit=2 → credit stays 2.
- Timeout: grant packer 2, which sends 3 beats and never sends wlast → at cycle TIMEOUT+1 after grant, o_timeout=1 and o_timeout_id=2. credit and slot_ptr unchanged. The next grant goes to packer 3 if it is requesting.
- Interference and reset: packer 1 sends wen while packer 0 is granted → no output beats from packer 1. rst_n pulled low mid-packet → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/cpri_tx_pkg_sched.sv
// Round-robin packet scheduler sharing one CPRI TX buffer write port among four UL packers.
// Latency: grant 1 cycle after request is sampled in IDLE; granted beats forwarded 1 cycle after input.
// Backpressure: no grant while buffer credit is zero; a grant held TIMEOUT cycles without wlast is aborted.
module cpri_tx_pkg_sched #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 64,
    parameter int NUM_BUF = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                i_req,
    output logic [NUM_REQ-1:0]                o_gnt,
    input  logic [NUM_REQ-1:0]                i_wen,
    input  logic [NUM_REQ*ADDR_W-1:0]         i_waddr,
    input  logic [NUM_REQ*DATA_W-1:0]         i_wdata,
    input  logic [NUM_REQ-1:0]                i_wlast,
    input  logic                              i_buf_rel,
    output logic                              o_cpri_wen,
    output logic [$clog2(NUM_BUF)+ADDR_W-1:0] o_cpri_waddr,
    output logic [DATA_W-1:0]                 o_cpri_wdata,
    output logic                              o_cpri_wlast,
    output logic [$clog2(NUM_BUF):0]          o_credit,
    output logic                              o_timeout,
    output logic [1:0]                        o_timeout_id,
    output logic [15:0]                       o_pkt_cnt
);

    localparam int SLOT_W = $clog2(NUM_BUF);
    localparam int CRED_W = SLOT_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          cur_id;
    logic [1:0]          last_winner;
    logic [1:0]          pick_id;
    logic                pick_vld;
    logic                start;
    logic                done;
    logic                expire;
    logic                g_wen;
    logic                g_wlast;
    logic [ADDR_W-1:0]   g_waddr;
    logic [DATA_W-1:0]   g_wdata;
    logic [TMR_W-1:0]    timer;
    logic [SLOT_W-1:0]   slot_ptr;

    // Round-robin pick: first requester at or after last_winner+1.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = 1; i <= 4; i++) begin
            if (!pick_vld && i_req[2'(last_winner + 2'(i))]) begin
                pick_vld = 1'b1;
                pick_id  = 2'(last_winner + 2'(i));
            end
        end
    end

    // Select the granted packer's beat lane.
    always_comb begin
        g_wen   = i_wen[cur_id];
        g_wlast = i_wlast[cur_id];
        g_waddr = i_waddr[cur_id*ADDR_W +: ADDR_W];
        g_wdata = i_wdata[cur_id*DATA_W +: DATA_W];
    end

    // Scheduling events: new grant, packet completion, watchdog expiry.
    always_comb begin
        start  = (state == IDLE) && (o_credit != '0) && pick_vld;
        done   = (state == XFER) && g_wen && g_wlast;
        expire = (state == XFER) && !done && (timer == TMR_W'(TIMEOUT - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = XFER;
            XFER: begin
                if (done)        state_nxt = IDLE;
                else if (expire) state_nxt = ABORT;
            end
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant vector and owner index; grant drops on completion or expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gnt  <= '0;
            cur_id <= '0;
        end else if (start) begin
            o_gnt  <= NUM_REQ'(1) << pick_id;
            cur_id <= pick_id;
        end else if (done || expire) begin
            o_gnt  <= '0;
        end
    end

    // Watchdog timer: zero at grant, counts every XFER cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              timer <= '0;
        else if (start)          timer <= '0;
        else if (state == XFER)  timer <= timer + 1'b1;
    end

    // Forward the granted packer's beats with the slot pointer prepended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cpri_wen   <= 1'b0;
            o_cpri_wlast <= 1'b0;
            o_cpri_waddr <= '0;
            o_cpri_wdata <= '0;
        end else begin
            o_cpri_wen   <= (state == XFER) && g_wen;
            o_cpri_wlast <= done;
            if ((state == XFER) && g_wen) begin
                o_cpri_waddr <= {slot_ptr, g_waddr};
                o_cpri_wdata <= g_wdata;
            end
        end
    end

    // Slot pointer, packet count and credit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ptr  <= '0;
            o_pkt_cnt <= '0;
            o_credit  <= CRED_W'(NUM_BUF);
        end else begin
            if (done) begin
                slot_ptr  <= slot_ptr + 1'b1;
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
            end
            if (done && !i_buf_rel)
                o_credit <= o_credit - 1'b1;
            else if (i_buf_rel && !done && (o_credit != CRED_W'(NUM_BUF)))
                o_credit <= o_credit + 1'b1;
        end
    end

    // Round-robin pointer and abort reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner  <= 2'd3;
            o_timeout    <= 1'b0;
            o_timeout_id <= '0;
        end else begin
            o_timeout <= (state == ABORT);
            if (state == ABORT) begin
                o_timeout_id <= cur_id;
                last_winner  <= cur_id;
            end else if (done) begin
                last_winner  <= cur_id;
            end
        end
    end

endmodule

// File: tb/tb_cpri_tx_pkg_sched.sv
// Self-checking bench for cpri_tx_pkg_sched: directed scenarios plus randomized traffic.
// Expected outputs come from a packet-level reference model advanced once per clock.
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
module tb_cpri_tx_pkg_sched;

    localparam int NR = 4;
    localparam int AW = 7;
    localparam int DW = 64;
    localparam int NB = 4;
    localparam int TO = 256;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req;
    logic [3:0]       wen;
    logic [3:0]       wlast;
    logic [NR*AW-1:0] waddr;
    logic [NR*DW-1:0] wdata;
    logic             rel;
    logic [3:0]       gnt;
    logic             cwen;
    logic             cwlast;
    logic [SW+AW-1:0] cwaddr;
    logic [DW-1:0]    cwdata;
    logic [SW:0]      credit;
    logic             to;
    logic [1:0]       tid;
    logic [15:0]      cnt;

    int checks = 0;
    int failures = 0;

    // reference model state
    int               m_owner;
    int               m_abort;
    int               m_age;
    int               m_last;
    int               m_slot;
    int               m_credit;
    logic [3:0]       e_gnt;
    logic             e_wen;
    logic             e_wlast;
    logic             e_to;
    logic [1:0]       e_tid;
    logic [SW+AW-1:0] e_waddr;
    logic [DW-1:0]    e_wdata;
    logic [15:0]      e_cnt;

    int         bc [4];
    logic [3:0] gq [$];
    logic [3:0] exp_ord [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

    always #5 clk = ~clk;

    cpri_tx_pkg_sched #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_BUF(NB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(req), .o_gnt(gnt),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_wlast(wlast),
        .i_buf_rel(rel),
        .o_cpri_wen(cwen), .o_cpri_waddr(cwaddr), .o_cpri_wdata(cwdata), .o_cpri_wlast(cwlast),
        .o_credit(credit), .o_timeout(to), .o_timeout_id(tid), .o_pkt_cnt(cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic mdl_reset();
        m_owner = -1; m_abort = -1; m_age = 0; m_last = 3; m_slot = 0; m_credit = NB;
        e_gnt = '0; e_wen = 1'b0; e_wlast = 1'b0; e_to = 1'b0; e_tid = '0;
        e_waddr = '0; e_wdata = '0; e_cnt = '0;
    endtask

    // One clock of the packet-level model, using the inputs present at the edge.
    task automatic model_step();
        int done;
        done = 0;
        e_wen = 1'b0; e_wlast = 1'b0; e_to = 1'b0;
        if (m_owner >= 0) begin
            if (wen[m_owner]) begin
                e_wen   = 1'b1;
                e_waddr = {SW'(m_slot), waddr[m_owner*AW +: AW]};
                e_wdata = wdata[m_owner*DW +: DW];
                e_wlast = wlast[m_owner];
            end
            if (wen[m_owner] && wlast[m_owner]) begin
                done    = 1;
                m_last  = m_owner;
                e_cnt   = e_cnt + 16'd1;
                m_slot  = (m_slot + 1) % NB;
                m_owner = -1;
                e_gnt   = '0;
            end else if (m_age == TO - 1) begin
                m_abort = m_owner;
                m_owner = -1;
                e_gnt   = '0;
            end else begin
                m_age++;
            end
        end else if (m_abort >= 0) begin
            e_to    = 1'b1;
            e_tid   = 2'(m_abort);
            m_last  = m_abort;
            m_abort = -1;
        end else if (m_credit > 0 && req != 4'd0) begin
            for (int i = 1; i <= 4; i++) begin
                if (m_owner < 0 && req[(m_last + i) % 4]) m_owner = (m_last + i) % 4;
            end
            e_gnt = 4'(1 << m_owner);
            m_age = 0;
        end
        m_credit = m_credit + int'(rel) - done;
        if (m_credit > NB) m_credit = NB;
    endtask

    task automatic compare_all();
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("cpri_wen", 64'(cwen), 64'(e_wen));
        chk("cpri_wlast", 64'(cwlast), 64'(e_wlast));
        chk("credit", 64'(credit), 64'(m_credit));
        chk("timeout", 64'(to), 64'(e_to));
        chk("timeout_id", 64'(tid), 64'(e_tid));
        chk("pkt_cnt", 64'(cnt), 64'(e_cnt));
        if (e_wen) begin
            chk("cpri_waddr", 64'(cwaddr), 64'(e_waddr));
            chk("cpri_wdata", cwdata, e_wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        req = '0; wen = '0; wlast = '0; waddr = '0; wdata = '0; rel = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        mdl_reset();
        for (int k = 0; k < 4; k++) bc[k] = 0;
        gq.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Single packer, sequential beats addr 0..len-1, data base+i.
    task automatic send_pkt(input int k, input int len, input logic [63:0] base, input bit rel_last);
        req = '0; req[k] = 1'b1;
        tick();
        chk("pkt_gnt", 64'(gnt), 64'(1 << k));
        req = '0;
        for (int i = 0; i < len; i++) begin
            wen = '0; wlast = '0;
            wen[k] = 1'b1;
            wlast[k] = (i == len - 1);
            waddr[k*AW +: AW] = AW'(i);
            wdata[k*DW +: DW] = base + 64'(i);
            rel = rel_last && (i == len - 1);
            tick();
            chk("pkt_waddr", 64'(cwaddr[AW-1:0]), 64'(i));
        end
        wen = '0; wlast = '0; rel = 1'b0;
    endtask

    // Reactive packer traffic: granted packer sends beats, others optionally send junk.
    // plen>0: fixed length; plen==0: random wlast 1/8; plen<0: rare wlast (stalls).
    task automatic run_auto(input int n, input logic [3:0] reqm, input bit rndreq,
                            input int plen, input int relmode, input bit junk, input bit rr_chk);
        logic [3:0] pg;
        for (int c = 0; c < n; c++) begin
            req = rndreq ? 4'($urandom) : reqm;
            case (relmode)
                1:       rel = cwlast;
                2:       rel = ($urandom_range(0, 4) == 0);
                3:       rel = ($urandom_range(0, 39) == 0);
                default: rel = 1'b0;
            endcase
            for (int k = 0; k < 4; k++) begin
                if (gnt[k]) begin
                    wen[k] = (plen > 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (plen > 0)       wlast[k] = (bc[k] == plen - 1);
                    else if (plen == 0) wlast[k] = ($urandom_range(0, 7) == 0);
                    else                wlast[k] = ($urandom_range(0, 299) == 0);
                    waddr[k*AW +: AW] = AW'(bc[k]);
                    wdata[k*DW +: DW] = {$urandom, $urandom};
                    if (wen[k]) bc[k] = wlast[k] ? 0 : bc[k] + 1;
                end else begin
                    wen[k] = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                    wlast[k] = 1'($urandom_range(0, 1));
                    waddr[k*AW +: AW] = AW'($urandom);
                    wdata[k*DW +: DW] = {$urandom, $urandom};
                end
            end
            pg = gnt;
            tick();
            if (pg == 4'd0 && gnt != 4'd0) gq.push_back(gnt);
            if (rr_chk) chk("rr_credit_range", 64'(credit >= 3'd3), 64'd1);
        end
        wen = '0; wlast = '0; rel = 1'b0; req = '0;
    endtask

    initial begin
        clear_inputs();
        mdl_reset();
        do_reset();

        // single packer 0, 8 beats
        send_pkt(0, 8, 64'hA0, 1'b0);
        chk("t1_credit", 64'(credit), 64'd3);
        chk("t1_pkt_cnt", 64'(cnt), 64'd1);
        chk("t1_last_addr", 64'(cwaddr), 64'h007);
        chk("t1_last_data", cwdata, 64'hA7);
        tick();

        // round robin with release after each completion
        do_reset();
        run_auto(30, 4'hF, 1'b0, 4, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            chk("rr_order", 64'((i < gq.size()) ? gq[i] : 4'hF), 64'(exp_ord[i]));

        // credit exhaustion, then one release
        do_reset();
        run_auto(25, 4'hF, 1'b0, 2, 0, 1'b0, 1'b0);
        chk("exh_credit", 64'(credit), 64'd0);
        chk("exh_pkt_cnt", 64'(cnt), 64'd4);
        req = 4'hF;
        tick();
        chk("exh_no_gnt", 64'(gnt), 64'd0);
        rel = 1'b1;
        tick();
        chk("exh_rel_credit", 64'(credit), 64'd1);
        chk("exh_rel_no_gnt_yet", 64'(gnt), 64'd0);
        rel = 1'b0;
        tick();
        chk("exh_rel_gnt", 64'(gnt), 64'h1);

        // release coincident with completion at credit 2
        do_reset();
        send_pkt(0, 2, 64'h10, 1'b0);
        tick();
        send_pkt(0, 2, 64'h20, 1'b0);
        chk("coin_pre_credit", 64'(credit), 64'd2);
        send_pkt(1, 2, 64'h30, 1'b1);
        chk("coin_credit", 64'(credit), 64'd2);

        // timeout on packer 2; packer 3 waits
        do_reset();
        req = 4'b1100;
        tick();
        chk("to_gnt", 64'(gnt), 64'h4);
        for (int c = 1; c <= TO + 1; c++) begin
            wen = '0; wlast = '0;
            wen[2] = (c <= 3);
            waddr[2*AW +: AW] = AW'(c - 1);
            wdata[2*DW +: DW] = 64'(c);
            tick();
            chk("to_flag", 64'(to), 64'(c == TO + 1));
        end
        wen = '0;
        chk("to_id", 64'(tid), 64'd2);
        chk("to_credit", 64'(credit), 64'd4);
        tick();
        chk("to_next_gnt", 64'(gnt), 64'h8);
        req = '0;
        wen[3] = 1'b1; wlast[3] = 1'b1; waddr[3*AW +: AW] = 7'h05; wdata[3*DW +: DW] = 64'hBEEF;
        tick();
        chk("to_slot_reuse", 64'(cwaddr), 64'h005);
        wen = '0; wlast = '0;

        // interference from other packers, then reset mid-packet
        do_reset();
        run_auto(14, 4'b0001, 1'b0, 5, 1, 1'b1, 1'b0);
        chk("intf_pkt_cnt", 64'(cnt), 64'd2);
        chk("intf_gnt_mid", 64'(gnt), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_wen", 64'(cwen), 64'd0);
        chk("rst_waddr", 64'(cwaddr), 64'd0);
        chk("rst_wdata", cwdata, 64'd0);
        chk("rst_wlast", 64'(cwlast), 64'd0);
        chk("rst_credit", 64'(credit), 64'd4);
        chk("rst_pkt_cnt", 64'(cnt), 64'd0);
        chk("rst_timeout", 64'(to), 64'd0);
        do_reset();
        send_pkt(0, 3, 64'h55, 1'b0);
        chk("post_rst_addr", 64'(cwaddr), 64'h002);

        // randomized traffic
        do_reset();
        run_auto(3000, 4'h0, 1'b1, 0, 2, 1'b1, 1'b0);
        run_auto(3000, 4'h0, 1'b1, 0, 3, 1'b1, 1'b0);
        run_auto(3000, 4'h0, 1'b1, -1, 2, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
